// File: rtl/target_judge.sv
// Latches a nonzero random target, lights its LED, and judges the player's guess or a timeout.
// Optional MISS_PENALTY_EN: when defined, every miss decrements the score (saturating at 0).
module target_judge #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int SCORE_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active,
    input  logic [2:0]         target,
    input  logic [2:0]         guess,
    input  logic               press,
    output logic [7:0]         led,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    state_t             state, state_next;
    logic [2:0]         tgt, tgt_next;
    logic [TW-1:0]      timer, timer_next;
    logic               press_q;
    logic               press_edge;
    logic [7:0]         led_next;
    logic               hit_next, miss_next, busy_next;
    logic [SCORE_W-1:0] score_next;

    assign press_edge = press & ~press_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tgt     <= '0;
            timer   <= '0;
            press_q <= 1'b0;
            led     <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            tgt     <= tgt_next;
            timer   <= timer_next;
            press_q <= press;
            led     <= led_next;
            hit     <= hit_next;
            miss    <= miss_next;
            score   <= score_next;
            busy    <= busy_next;
        end
    end

    // A dropped enable overrides everything, so an edge in that cycle is never judged.
    always_comb begin
        state_next = state;
        tgt_next   = tgt;
        timer_next = timer;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
        score_next = score;

        if (!active) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = LOAD;
                LOAD: begin
                    if (target != 3'b000) begin
                        tgt_next   = target;
                        timer_next = '0;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (press_edge) begin
                        if (guess == tgt) begin
                            hit_next = 1'b1;
                            if (score != SCORE_MAX) score_next = score + 1'b1;
                        end else begin
                            miss_next = 1'b1;
                        end
                        state_next = LOAD;
                    end else if (timer == TIMER_LAST) begin
                        miss_next  = 1'b1;
                        state_next = LOAD;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

`ifdef MISS_PENALTY_EN
        if (miss_next && (score != '0)) score_next = score - 1'b1;
`endif

        // Display outputs are registered from the next state so they track WAIT exactly.
        busy_next = (state_next == WAIT);
        led_next  = busy_next ? (8'b1 << tgt_next) : 8'b0;
    end

endmodule

// File: tb/tb_target_judge.sv
// Scoreboard bench for target_judge: stimulus pushes model expectations, a negedge monitor checks them.
module tb_target_judge;

    localparam int T    = 8;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       reset, active, press;
    logic [2:0] target, guess;
    logic [7:0] led;
    logic       hit, miss, busy;
    logic [3:0] score;

    typedef struct packed {
        logic [7:0] led;
        logic       hit;
        logic       miss;
        logic [3:0] score;
        logic       busy;
    } out_t;

    out_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = waiting for a target, 2 = showing a target
    int m_phase = 0;
    int m_tgt = 0;
    int m_waited = 0;
    int m_score = 0;
    bit m_press_q = 0;
    int cur_t = 5;

    target_judge #(.TIMEOUT_CYCLES(T), .SCORE_W(4)) dut (
        .clk(clk), .reset(reset), .active(active), .target(target), .guess(guess),
        .press(press), .led(led), .hit(hit), .miss(miss), .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input out_t e);
        out_t a;
        a = '{led: led, hit: hit, miss: miss, score: score, busy: busy};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL outputs @%0t: actual led=%b hit=%b miss=%b score=%0d busy=%b, required led=%b hit=%b miss=%b score=%0d busy=%b",
                     $time, a.led, a.hit, a.miss, a.score, a.busy, e.led, e.hit, e.miss, e.score, e.busy);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input bit r, input bit a, input int t, input int g, input bit p);
        bit   edge_b;
        bit   eh, em;
        out_t e;
        @(negedge clk);
        #1;
        reset = r; active = a; target = t[2:0]; guess = g[2:0]; press = p;
        eh = 0; em = 0;
        if (r) begin
            m_phase = 0; m_tgt = 0; m_waited = 0; m_score = 0; m_press_q = 0;
        end else begin
            edge_b = p && !m_press_q;
            if (!a) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (t != 0) begin
                    m_tgt = t; m_waited = 0; m_phase = 2;
                end
            end else begin
                if (edge_b) begin
                    if (g == m_tgt) begin
                        eh = 1;
                        if (m_score < SMAX) m_score++;
                    end else begin
                        em = 1;
                    end
                    m_phase = 1;
                end else if (m_waited + 1 == T) begin
                    em = 1;
                    m_phase = 1;
                end else begin
                    m_waited++;
                end
`ifdef MISS_PENALTY_EN
                if (em && m_score > 0) m_score--;
`endif
            end
            m_press_q = p;
        end
        e.led   = (m_phase == 2) ? (8'd1 << m_tgt) : 8'd0;
        e.hit   = eh;
        e.miss  = em;
        e.score = 4'(m_score);
        e.busy  = (m_phase == 2);
        exp_q.push_back(e);
    endtask

    task automatic goToWait(input int t);
        for (int i = 0; i < 40 && m_phase != 2; i++) applyStimulus(0, 1, t, 0, 0);
        checks++;
        if (m_phase != 2) begin
            errors++;
            $display("[TB] FAIL goToWait: actual phase=%0d, required phase=2", m_phase);
        end
    endtask

    task automatic pressOnce(input int g);
        applyStimulus(0, 1, cur_t, g, 1);
        applyStimulus(0, 1, cur_t, g, 0);
    endtask

    initial begin
        reset = 1; active = 1; target = 3'd5; guess = 3'd0; press = 0;

        repeat (3) applyStimulus(1, 1, 5, 0, 0);
        cur_t = 5;
        goToWait(cur_t);
        repeat (2) applyStimulus(0, 1, cur_t, 0, 0);

        // Correct guess with press held afterwards: exactly one hit
        applyStimulus(0, 1, cur_t, 5, 1);
        repeat (6) applyStimulus(0, 1, cur_t, 5, 1);
        applyStimulus(0, 1, cur_t, 5, 0);

        goToWait(cur_t);
        pressOnce(3);

        // Timeout with no press
        goToWait(cur_t);
        repeat (10) applyStimulus(0, 1, cur_t, 0, 0);

        // Correct press on the last allowed WAIT cycle
        goToWait(cur_t);
        for (int i = 0; i < 20 && m_waited < T - 1; i++) applyStimulus(0, 1, cur_t, 0, 0);
        pressOnce(5);

        // Target held at zero stays in LOAD
        goToWait(cur_t);
        cur_t = 0;
        pressOnce(1);
        repeat (20) applyStimulus(0, 1, 0, 0, 0);
        cur_t = 2;
        goToWait(cur_t);

        // Saturate the score
        for (int i = 0; i < 17; i++) begin
            goToWait(cur_t);
            pressOnce(m_tgt);
        end

        // Drop active with a press edge in the same cycle
        goToWait(cur_t);
        applyStimulus(0, 0, cur_t, cur_t, 1);
        repeat (3) applyStimulus(0, 0, cur_t, cur_t, 0);

        // Reset mid-WAIT
        goToWait(cur_t);
        repeat (2) applyStimulus(0, 1, cur_t, 0, 0);
        repeat (2) applyStimulus(1, 1, cur_t, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, a, p;
            int t, g;
            r = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 99) < 92);
            t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
            g = ($urandom_range(0, 1) == 0) ? m_tgt : int'($urandom_range(0, 7));
            p = ($urandom_range(0, 3) == 0);
            applyStimulus(r, a, t, g, p);
        end

        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
